// File: rtl/fc_ctrl_pkg.sv
// rtl/fc_ctrl_pkg.sv - shared state encoding and default sizing for the fc layer control path
package fc_ctrl_pkg;

    localparam int FC_ADDR_W     = 8;
    localparam int FC_IDX_W      = 7;
    localparam int FC_MAX_INPUTS = 100;
    localparam int FC_RD_LAT     = 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - read-latency delay line carrying {valid, input index}
module rd_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             pending
);

    logic [DEPTH-1:0] valid;
    logic [IDX_W-1:0] idx [DEPTH];

    // Index fields only advance with a valid entry so the output holds its last index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx[i] <= '0;
            end
        end else begin
            valid[0] <= in_valid;
            if (in_valid) begin
                idx[0] <= in_idx;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                if (valid[i-1]) begin
                    idx[i] <= idx[i-1];
                end
            end
        end
    end

    // Entries still upstream of the output stage; the last stage is already visible.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | valid[i];
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - sequences one fully-connected layer pass over weight memory and MAC
module fc_layer_sequencer
    import fc_ctrl_pkg::*;
#(
    parameter int ADDR_W     = FC_ADDR_W,
    parameter int IDX_W      = FC_IDX_W,
    parameter int MAX_INPUTS = FC_MAX_INPUTS,
    parameter int RD_LAT     = FC_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [IDX_W-1:0]  n_inputs,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [IDX_W-1:0]  input_idx,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              out_load
);

    localparam logic [IDX_W-1:0] MAX_N = IDX_W'(MAX_INPUTS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  n_eff;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  k_next;
    logic              issue_valid;
    logic              pending;

    assign k_next      = k + IDX_W'(1);
    assign issue_valid = (state == ST_ISSUE) && (n_eff != '0);

    // Outputs are registered alongside the state so each reflects the state it enters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            n_eff       <= '0;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mac_clear   <= 1'b0;
            out_load    <= 1'b0;
            weight_addr <= '0;
        end else begin
            mac_clear <= 1'b0;
            out_load  <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        n_eff       <= (n_inputs > MAX_N) ? MAX_N : n_inputs;
                        k           <= '0;
                        weight_addr <= base_addr;
                        mac_clear   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (n_eff == '0) begin
                        out_load <= 1'b1;
                        state    <= ST_LOAD;
                    end else if (k_next == n_eff) begin
                        state <= ST_DRAIN;
                    end else begin
                        k           <= k_next;
                        weight_addr <= base_q + ADDR_W'(k_next);
                    end
                end
                ST_DRAIN: begin
                    if (!pending) begin
                        out_load <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    rd_lat_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_idx    (k),
        .out_valid (mac_en),
        .out_idx   (input_idx),
        .pending   (pending)
    );

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Controller that sequences one fully-connected layer pass over the weight memory and MAC datapath. On a start request it walks the weight memory row by row and steps the input-element index in step with it. It also generates accumulator clear/enable strobes aligned to the memory read latency, then commands the output register load and signals completion. It sits between the network-level control and the `weightMemory` + `layer` pair; those blocks hold no sequencing of their own.

## Interface
- `ADDR_W`, 8: weight memory address width.
- `IDX_W`, 7: input-element index width.
- `MAX_INPUTS`, 100: largest legal layer length (input elements per pass).
- `RD_LAT`, 1: weight memory read latency in cycles (≥1).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: pass request, sampled only in IDLE.
- `base_addr` in ADDR_W: first weight row of this layer, latched on accepted start.
- `n_inputs` in IDX_W: input elements in this pass, latched on accepted start.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse; `output_fc` register is valid this cycle.
- `weight_addr` out ADDR_W: address to `weightMemory`.
- `input_idx` out IDX_W: index of the `input_fc` element matching the weights present on a `mac_en` cycle.
- `mac_clear` out 1: zero all 32 accumulators.
- `mac_en` out 1: accumulate one input element × weight row.
- `out_load` out 1: capture accumulators into the output register.

## Operation
- States: IDLE, ISSUE, DRAIN, LOAD, DONE.
- IDLE:
  - `start`=1 → latch `base_addr` and `n_eff`. `n_eff` = min(`n_inputs`, MAX_INPUTS).
  - Clear the issue counter k=0.
  - Go to ISSUE.
- ISSUE:
  - Drive `weight_addr` = base+k, modulo 2^ADDR_W; addresses wrap silently.
  - First ISSUE cycle asserts `mac_clear`.
  - Push {valid, k} into an RD_LAT-deep delay line; k++.
  - After issuing k = n_eff−1 → DRAIN.
- DRAIN: no new issue; stay until the delay line is empty → LOAD.
- Delay-line output drives `mac_en` and `input_idx` in every state.
- LOAD: `out_load`=1 for one cycle → DONE.
- DONE: `done`=1, `busy`=0, one cycle → IDLE.
- `busy`=1 in ISSUE, DRAIN and LOAD.
- `n_eff`=0:
  - The first ISSUE cycle asserts `mac_clear` with no valid pushed and no `mac_en`.
  - Then LOAD, then DONE.
- `start` outside IDLE is ignored. `start` held high restarts a new pass the cycle after DONE.
- `base_addr`/`n_inputs` changes during a pass have no effect.
- `reset` mid-pass: return to IDLE immediately and flush the delay line. No `done` is issued; the partial accumulation is abandoned.

## Timing
- Cycle 0 = edge at which `start` is accepted.
- Cycle 1: first ISSUE; `mac_clear`=1, `weight_addr`=base.
- Cycles 1..n: `weight_addr` = base+0 … base+n−1.
- Cycles 1+RD_LAT … n+RD_LAT: `mac_en`=1 with `input_idx` = 0 … n−1, gap-free.
- `mac_clear` is never coincident with `mac_en`, since RD_LAT≥1.
- Cycle n+RD_LAT+1: `out_load`.
- Cycle n+RD_LAT+2: `done`.
- n=100, RD_LAT=1: `done` at cycle 103; next `start` accepted at cycle 104 at earliest.
- n=0: `mac_clear` cycle 1, `out_load` cycle 2, `done` cycle 3.
- Reset values: `busy`=0, `done`=0, `mac_clear`=0, `mac_en`=0, `out_load`=0, `weight_addr`=0, `input_idx`=0.
- All outputs are registered.
- `weight_addr` holds its last value outside ISSUE.
- `input_idx` holds its last value when `mac_en`=0.

## Structure
- Shared package `fc_ctrl_pkg`:
  - state encoding (IDLE…DONE);
  - default ADDR_W/IDX_W/MAX_INPUTS/RD_LAT constants, reused by `layer` and `weightMemory`.
- Sub-module `rd_lat_pipe`: parameterised RD_LAT-deep shift register of {valid, IDX_W index}, with an async reset that clears all valid bits.
- Top: FSM, issue counter, and clamp logic.

## Test plan
- Reset, then `start` with base=0, n=100, RD_LAT=1:
  - addresses 0..99 on cycles 1..100;
  - `mac_en` cycles 2..101 with idx 0..99;
  - `out_load` at 102, `done` at 103;
  - exactly 100 `mac_en`.
- base=250, n=10: addresses 250..255, then 0..3 (wrap); `done` at cycle 13.
- n=0: `mac_clear` at cycle 1, no `mac_en`, `out_load` at 2, `done` at 3.
- n=127, MAX_INPUTS=100: clamped to 100 `mac_en`; `start` pulses during busy are ignored (single `done`).
- `reset` asserted at cycle 50 of a pass:
  - all outputs 0 asynchronously;
  - no `done`;
  - a fresh `start` then completes normally.
- RD_LAT=3, n=5: `mac_en` cycles 4..8, `out_load` 9, `done` 10; `start` held high → second pass accepted at cycle 11.
